// File: rtl/gatefn_seq_sched.sv
// Time-shares one external 3-evaluation gate function unit across the gates of a layer:
// issues enabled gates in ascending order, waits for each completion and banks the results.
`ifndef F_NBITS
`define F_NBITS 8
`endif

module gatefn_seq_sched #(
  parameter int ngates   = 4,
  parameter int idx_bits = (ngates > 1) ? $clog2(ngates) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    mux_sel,
  input  logic [ngates-1:0]                       gate_mask,
  input  logic [ngates-1:0][2:0][`F_NBITS-1:0]    in0,
  input  logic [ngates-1:0][2:0][`F_NBITS-1:0]    in1,
  output logic                                    fn_en,
  output logic                                    fn_mux_sel,
  output logic [2:0][`F_NBITS-1:0]                fn_in0,
  output logic [2:0][`F_NBITS-1:0]                fn_in1,
  input  logic                                    fn_ready_pulse,
  input  logic [2:0][`F_NBITS-1:0]                fn_gatefn,
  output logic [ngates-1:0][2:0][`F_NBITS-1:0]    result,
  output logic [idx_bits-1:0]                     gate_idx,
  output logic                                    busy,
  output logic                                    ready,
  output logic                                    ready_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                                  state_r;
  state_t                                  next_s;
  logic [idx_bits-1:0]                     gate_idx_r;
  logic [ngates-1:0]                       mask_r;
  logic                                    mux_sel_r;
  logic                                    fn_en_r;
  logic                                    busy_r;
  logic                                    ready_r;
  logic                                    ready_pulse_r;
  logic [ngates-1:0][2:0][`F_NBITS-1:0]    result_r;

  logic                                    accept_s;
  logic                                    capture_s;
  logic [ngates-1:0]                       search_mask_s;
  int                                      search_lo_s;
  logic [idx_bits:0]                       hit_s;

  // Lowest set bit of m at or above lo; MSB of the return value flags a hit. Never wraps.
  function automatic logic [idx_bits:0] find_set(input logic [ngates-1:0] m, input int lo);
    logic [idx_bits:0] r;
    r = '0;
    for (int i = ngates - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) begin
        r = {1'b1, idx_bits'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Start acceptance, next-gate search and next-state decode.
  always_comb begin
    accept_s      = start && ((state_r == IDLE) || (state_r == DONE));
    capture_s     = (state_r == WAIT) && fn_ready_pulse;
    search_mask_s = gate_mask;
    search_lo_s   = 32'sd0;
    if (state_r == WAIT) begin
      search_mask_s = mask_r;
      search_lo_s   = int'(gate_idx_r) + 32'sd1;
    end else begin
      search_mask_s = gate_mask;
      search_lo_s   = 32'sd0;
    end
    hit_s  = find_set(search_mask_s, search_lo_s);
    next_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          if (hit_s[idx_bits]) begin
            next_s = ISSUE;
          end else begin
            next_s = DONE;
          end
        end else begin
          next_s = state_r;
        end
      end
      ISSUE: begin
        // A pulse seen here is left over from the previous op and is deliberately ignored.
        next_s = WAIT;
      end
      WAIT: begin
        if (capture_s) begin
          if (hit_s[idx_bits]) begin
            next_s = ISSUE;
          end else begin
            next_s = DONE;
          end
        end else begin
          next_s = WAIT;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // State register, pass configuration and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      gate_idx_r    <= '0;
      mask_r        <= '0;
      mux_sel_r     <= 1'b0;
      fn_en_r       <= 1'b0;
      busy_r        <= 1'b0;
      ready_r       <= 1'b0;
      ready_pulse_r <= 1'b0;
    end else begin
      state_r       <= next_s;
      fn_en_r       <= (next_s == ISSUE);
      busy_r        <= (next_s == ISSUE) || (next_s == WAIT);
      ready_r       <= (next_s == DONE);
      ready_pulse_r <= (next_s == DONE) && ((state_r != DONE) || accept_s);
      if (accept_s) begin
        mux_sel_r <= mux_sel;
        mask_r    <= gate_mask;
      end
      if ((accept_s || capture_s) && hit_s[idx_bits]) begin
        gate_idx_r <= hit_s[idx_bits-1:0];
      end
    end
  end

  // Result bank: disabled gates cleared on an accepted start, enabled gates written on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r <= '0;
    end else if (accept_s) begin
      for (int g = 0; g < ngates; g++) begin
        if (!gate_mask[g]) begin
          result_r[g] <= '0;
        end
      end
    end else if (capture_s) begin
      result_r[gate_idx_r] <= fn_gatefn;
    end
  end

  assign fn_en       = fn_en_r;
  assign fn_mux_sel  = mux_sel_r;
  assign fn_in0      = in0[gate_idx_r];
  assign fn_in1      = in1[gate_idx_r];
  assign result      = result_r;
  assign gate_idx    = gate_idx_r;
  assign busy        = busy_r;
  assign ready       = ready_r;
  assign ready_pulse = ready_pulse_r;

endmodule

// File: tb/tb_gatefn_seq_sched.sv
// Bench for gatefn_seq_sched: a stub gatefn unit with configurable latency plus a
// pass-level reference model (enabled gates in order, per-gate cost, result bank contents).
`ifndef F_NBITS
`define F_NBITS 8
`endif

module tb_gatefn_seq_sched;
  localparam int NG = 4;
  localparam int FW = `F_NBITS;
  localparam int IW = 2;

  logic                         clk;
  logic                         rst;
  logic                         start;
  logic                         mux_sel;
  logic [NG-1:0]                gate_mask;
  logic [NG-1:0][2:0][FW-1:0]   in0;
  logic [NG-1:0][2:0][FW-1:0]   in1;
  logic                         fn_en;
  logic                         fn_mux_sel;
  logic [2:0][FW-1:0]           fn_in0;
  logic [2:0][FW-1:0]           fn_in1;
  logic                         fn_ready_pulse;
  logic [2:0][FW-1:0]           fn_gatefn;
  logic [NG-1:0][2:0][FW-1:0]   result;
  logic [IW-1:0]                gate_idx;
  logic                         busy;
  logic                         ready;
  logic                         ready_pulse;

  int checks = 0;
  int failures = 0;

  int   stub_lat = 3;
  bit   stub_stale = 1'b0;
  bit   stub_idx_pat = 1'b1;
  int   force_req = 0;
  logic exp_msel = 1'b0;

  int issued_q[$];
  int busy_cnt = 0;
  int msel_bad = 0;

  logic [FW-1:0] exp_res [NG][3];

  gatefn_seq_sched #(.ngates(NG)) dut (
    .clk(clk), .rst(rst), .start(start), .mux_sel(mux_sel), .gate_mask(gate_mask),
    .in0(in0), .in1(in1), .fn_en(fn_en), .fn_mux_sel(fn_mux_sel), .fn_in0(fn_in0),
    .fn_in1(fn_in1), .fn_ready_pulse(fn_ready_pulse), .fn_gatefn(fn_gatefn),
    .result(result), .gate_idx(gate_idx), .busy(busy), .ready(ready),
    .ready_pulse(ready_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behaviour of the external unit: either an index pattern or add/mul selected by mux_sel.
  function automatic logic [FW-1:0] unit_val(input bit idxp, input int g, input int e,
                                             input logic ms, input logic [FW-1:0] a,
                                             input logic [FW-1:0] b);
    logic [2*FW-1:0] p;
    if (idxp) return FW'(g * 16 + e);
    p = ms ? ({{FW{1'b0}}, a} * {{FW{1'b0}}, b}) : ({{FW{1'b0}}, a} + {{FW{1'b0}}, b});
    return p[FW-1:0];
  endfunction

  // Stub unit and monitor, acting on the falling edge.
  initial begin
    int cnt;
    int force_ack;
    cnt = 0;
    force_ack = 0;
    fn_ready_pulse = 1'b0;
    fn_gatefn = '0;
    forever begin
      @(negedge clk);
      fn_ready_pulse = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          fn_ready_pulse = 1'b1;
          for (int e = 0; e < 3; e++)
            fn_gatefn[e] = unit_val(stub_idx_pat, int'(gate_idx), e, fn_mux_sel, fn_in0[e], fn_in1[e]);
        end
      end
      if (force_req != force_ack) begin
        force_ack = force_req;
        fn_ready_pulse = 1'b1;
        for (int e = 0; e < 3; e++) fn_gatefn[e] = FW'(8'hA5);
      end
      if (fn_en === 1'b1) begin
        issued_q.push_back(int'(gate_idx));
        cnt = stub_lat + 1;
        if (stub_stale) begin
          fn_ready_pulse = 1'b1;
          for (int e = 0; e < 3; e++) fn_gatefn[e] = FW'(8'hEE);
        end
      end
      if (busy === 1'b1) begin
        busy_cnt++;
        if (fn_mux_sel !== exp_msel) msel_bad++;
      end
    end
  end

  task automatic randomize_operands();
    for (int g = 0; g < NG; g++)
      for (int e = 0; e < 3; e++) begin
        in0[g][e] = FW'($urandom);
        in1[g][e] = FW'($urandom);
      end
  endtask

  task automatic check_results(input string nm);
    for (int g = 0; g < NG; g++) begin
      checks++;
      if (result[g] !== {exp_res[g][2], exp_res[g][1], exp_res[g][0]}) begin
        failures++;
        $display("FAIL %s_result[%0d] got=%h exp=%h", nm, g, result[g],
                 {exp_res[g][2], exp_res[g][1], exp_res[g][0]});
      end
    end
  endtask

  // One pass; called at posedge+2 with the DUT in IDLE or DONE, returns at posedge+2 in DONE.
  task automatic run_pass(input string nm, input logic [NG-1:0] m, input logic ms,
                          input int lat, input bit stale, input bit idxp,
                          input bit poke, input bit linger);
    int exp_q[$];
    int n, k, base_i, base_b, base_m;
    bit done, early_rp, order_ok;
    stub_lat = lat;
    stub_stale = stale;
    stub_idx_pat = idxp;
    randomize_operands();
    gate_mask = m;
    mux_sel = ms;
    exp_msel = ms;
    start = 1'b1;
    base_i = issued_q.size();
    base_b = busy_cnt;
    base_m = msel_bad;
    n = 0;
    for (int g = 0; g < NG; g++) begin
      if (m[g]) begin
        exp_q.push_back(g);
        n++;
      end
      for (int e = 0; e < 3; e++)
        exp_res[g][e] = m[g] ? unit_val(idxp, g, e, ms, in0[g][e], in1[g][e]) : '0;
    end
    k = 0;
    done = 1'b0;
    early_rp = 1'b0;
    while (!done && k < 400) begin
      @(posedge clk); #2;
      k++;
      if (k == 1) start = 1'b0;
      if (poke && k == 3) begin
        start = 1'b1;
        gate_mask = ~m;
        mux_sel = ~ms;
      end
      if (poke && k == 4) begin
        start = 1'b0;
        gate_mask = m;
        mux_sel = ms;
      end
      if (k == 1 && n > 0) begin
        checks++;
        if (ready !== 1'b0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL %s_first_cycle got ready=%b busy=%b exp ready=0 busy=1", nm, ready, busy);
        end
      end
      if (ready === 1'b1) done = 1'b1;
      else if (ready_pulse !== 1'b0) early_rp = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout got no ready within %0d cycles", nm, k);
    end
    checks++;
    if (k != 1 + n * (2 + lat)) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=%0d", nm, k, 1 + n * (2 + lat));
    end
    checks++;
    if (ready_pulse !== 1'b1 || early_rp) begin
      failures++;
      $display("FAIL %s_ready_pulse got=%b early=%b exp=1 early=0", nm, ready_pulse, early_rp);
    end
    checks++;
    if (busy_cnt - base_b != n * (2 + lat)) begin
      failures++;
      $display("FAIL %s_busy_cycles got=%0d exp=%0d", nm, busy_cnt - base_b, n * (2 + lat));
    end
    order_ok = (issued_q.size() - base_i == n);
    for (int i = 0; i < n && order_ok; i++)
      if (issued_q[base_i + i] != exp_q[i]) order_ok = 1'b0;
    checks++;
    if (!order_ok) begin
      failures++;
      $display("FAIL %s_issue_order got_count=%0d exp_count=%0d mask=%b", nm,
               issued_q.size() - base_i, n, m);
    end
    checks++;
    if (msel_bad != base_m) begin
      failures++;
      $display("FAIL %s_fn_mux_sel got %0d bad cycles exp 0 (latched=%b)", nm, msel_bad - base_m, ms);
    end
    check_results(nm);
    if (linger) begin
      @(posedge clk); #2;
      checks++;
      if (ready !== 1'b1 || ready_pulse !== 1'b0) begin
        failures++;
        $display("FAIL %s_done_hold got ready=%b ready_pulse=%b exp 1 0", nm, ready, ready_pulse);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    mux_sel = 1'b0;
    gate_mask = '0;
    randomize_operands();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({fn_en, busy, ready, ready_pulse, fn_mux_sel} !== 5'b00000 || gate_idx !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs got en/busy/rdy/rp/msel=%b idx=%0d exp 00000 0",
               {fn_en, busy, ready, ready_pulse, fn_mux_sel}, gate_idx);
    end
    for (int g = 0; g < NG; g++)
      for (int e = 0; e < 3; e++) exp_res[g][e] = '0;
    check_results("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (fn_in0 !== in0[0] || fn_in1 !== in1[0] || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_mux got in0=%h in1=%h busy=%b exp in0=%h in1=%h busy=0",
               fn_in0, fn_in1, busy, in0[0], in1[0]);
    end
  endtask

  task automatic test_full();
    @(posedge clk); #2;
    run_pass("full", 4'b1111, 1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_sparse();
    @(posedge clk); #2;
    run_pass("sparse", 4'b1010, 1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_zero_mask();
    @(posedge clk); #2;
    run_pass("zero", 4'b0000, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_stale_and_poke();
    logic [NG-1:0] m;
    m = NG'($urandom_range(1, 15));
    @(posedge clk); #2;
    run_pass("stale_poke", m, 1'($urandom), 2, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_wait();
    int base_i, k;
    @(posedge clk); #2;
    stub_lat = 3;
    stub_stale = 1'b0;
    stub_idx_pat = 1'b0;
    randomize_operands();
    gate_mask = 4'b1111;
    mux_sel = 1'b1;
    exp_msel = 1'b1;
    base_i = issued_q.size();
    start = 1'b1;
    k = 0;
    while (issued_q.size() - base_i < 3 && k < 100) begin
      @(posedge clk); #2;
      start = 1'b0;
      k++;
    end
    checks++;
    if (issued_q.size() - base_i < 3 || gate_idx !== 2'd2 || busy !== 1'b1 || fn_en !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_reach_wait got issued=%0d idx=%0d busy=%b fn_en=%b exp 3 2 1 0",
               issued_q.size() - base_i, gate_idx, busy, fn_en);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0 || gate_idx !== 2'd0 || result !== '0) begin
      failures++;
      $display("FAIL rstmid_async got busy=%b ready=%b idx=%0d result=%h exp 0 0 0 0",
               busy, ready, gate_idx, result);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    base_i = issued_q.size();
    force_req++;
    repeat (6) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0 || gate_idx !== 2'd0 || result !== '0 ||
        issued_q.size() != base_i) begin
      failures++;
      $display("FAIL rstmid_stray_pulse got busy=%b ready=%b idx=%0d result=%h issues=%0d exp idle",
               busy, ready, gate_idx, result, issued_q.size() - base_i);
    end
    run_pass("rstmid_restart", 4'b0001, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [NG-1:0] m2;
    m2 = NG'($urandom_range(1, 15));
    @(posedge clk); #2;
    run_pass("b2b_first", 4'b0110, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_pass("b2b_second", m2, 1'b1, int'($urandom_range(0, 4)), 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      run_pass("random", NG'($urandom), 1'($urandom), int'($urandom_range(0, 5)),
               1'($urandom), 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_sparse();
    test_zero_mask();
    test_stale_and_poke();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
